// File: rtl/tournament_pkg.sv
// Shared sizing helpers and counter constants for the tournament chooser.
package tournament_pkg;

  localparam int unsigned PC_STEP = 4;

  function automatic int unsigned idx_width(input int unsigned entries);
    return (entries > 32'd1) ? $clog2(entries) : 32'd1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Counters start at the weakly-confident midpoint.
  function automatic int unsigned ctr_init(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/tournament_inflight_fifo.sv
// In-order queue of outstanding lookups awaiting resolution.
module tournament_inflight_fifo
  import tournament_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [WIDTH-1:0]               data_o,
  output logic [ptr_width(DEPTH):0]      count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: an entry is only read once counted.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tournament_n.sv
// Tournament chooser over NUM_PRED component predictors with per-entry confidence counters.
// Optional global-history index hashing is enabled by defining TOURNAMENT_GHIST_EN.
module tournament_n
  import tournament_pkg::*;
#(
  parameter int unsigned n        = 32,
  parameter int unsigned size     = 16,
  parameter int unsigned NUM_PRED = 2,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        lookup_valid,
  output logic                        lookup_ready,
  input  logic [n-1:0]                PC,
  input  logic [NUM_PRED-1:0]         pred_taken,
  input  logic [NUM_PRED*n-1:0]       pred_target,
  output logic                        pred_out_valid,
  output logic                        prediction,
  output logic [n-1:0]                nex_PC,
  output logic [$clog2(NUM_PRED)-1:0] chosen_idx,
  input  logic                        fix_valid,
  input  logic                        fix_result,
  output logic                        fix_error
);

  localparam int unsigned IDX_W = idx_width(size);
  localparam int unsigned SEL_W = $clog2(NUM_PRED);
  localparam int unsigned CNT_W = ptr_width(DEPTH) + 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic [NUM_PRED-1:0] taken;
  } q_entry_t;

  logic [CTR_W-1:0] ctr_q [size][NUM_PRED];
  logic [CTR_W-1:0] ctr_d [size][NUM_PRED];
  logic [IDX_W-1:0] idx_s;
  logic [SEL_W-1:0] sel_s;
  logic [CTR_W-1:0] best_s;
  logic             sel_taken_s;
  logic [n-1:0]     nex_s;
  logic             push_s, pop_s, full_s, empty_s;
  logic [CNT_W-1:0] count_s;
  q_entry_t         push_entry_s, head_s;

  logic             valid_q, prediction_q, fix_error_q;
  logic [n-1:0]     nex_pc_q;
  logic [SEL_W-1:0] chosen_q;

`ifdef TOURNAMENT_GHIST_EN
  logic [IDX_W-1:0] ghist_q, ghist_d;

  assign idx_s = PC[IDX_W+1:2] ^ ghist_q;

  always_comb begin
    ghist_d = ghist_q;
    if (pop_s) begin
      ghist_d = (ghist_q << 1) | IDX_W'(fix_result);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghist_q <= '0;
    end else begin
      ghist_q <= ghist_d;
    end
  end
`else
  assign idx_s = PC[IDX_W+1:2];
`endif

  assign lookup_ready = (count_s < CNT_W'(DEPTH));
  assign push_s       = lookup_valid && !full_s;
  assign pop_s        = fix_valid && !empty_s;
  assign push_entry_s = '{idx: idx_s, taken: pred_taken};

  tournament_inflight_fifo #(
    .WIDTH ($bits(q_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (push_entry_s),
    .data_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Strictly-greater compare keeps ties on the lowest predictor index.
  always_comb begin
    sel_s  = '0;
    best_s = ctr_q[idx_s][0];
    for (int p = 1; p < NUM_PRED; p++) begin
      if (ctr_q[idx_s][p] > best_s) begin
        best_s = ctr_q[idx_s][p];
        sel_s  = SEL_W'(p);
      end
    end
    sel_taken_s = pred_taken[sel_s];
    nex_s       = sel_taken_s ? pred_target[sel_s*n +: n] : PC + n'(PC_STEP);
  end

  always_comb begin
    ctr_d = ctr_q;
    if (pop_s) begin
      for (int p = 0; p < NUM_PRED; p++) begin
        if (head_s.taken[p] == fix_result) begin
          if (ctr_q[head_s.idx][p] != CTR_MAX) begin
            ctr_d[head_s.idx][p] = ctr_q[head_s.idx][p] + CTR_W'(1);
          end
        end else if (ctr_q[head_s.idx][p] != '0) begin
          ctr_d[head_s.idx][p] = ctr_q[head_s.idx][p] - CTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < size; i++) begin
        for (int p = 0; p < NUM_PRED; p++) begin
          ctr_q[i][p] <= CTR_INIT;
        end
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Result registers hold their last value between accepted lookups.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      prediction_q <= 1'b0;
      nex_pc_q     <= '0;
      chosen_q     <= '0;
      fix_error_q  <= 1'b0;
    end else begin
      valid_q     <= push_s;
      fix_error_q <= fix_valid && empty_s;
      if (push_s) begin
        prediction_q <= sel_taken_s;
        nex_pc_q     <= nex_s;
        chosen_q     <= sel_s;
      end
    end
  end

  assign pred_out_valid = valid_q;
  assign prediction     = prediction_q;
  assign nex_PC         = nex_pc_q;
  assign chosen_idx     = chosen_q;
  assign fix_error      = fix_error_q;

endmodule

// File: tb/tb_tournament_n.sv
// Directed table-driven bench for tournament_n at default parameters.
module tb_tournament_n;

  logic        clock = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [31:0] PC;
  logic [1:0]  pred_taken;
  logic [63:0] pred_target;
  logic        pred_out_valid;
  logic        prediction;
  logic [31:0] nex_PC;
  logic [0:0]  chosen_idx;
  logic        fix_valid;
  logic        fix_result;
  logic        fix_error;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] T0 = 32'h0000_0200;
  localparam logic [31:0] T1 = 32'h0000_0100;

  tournament_n dut (
    .clock          (clock),
    .reset          (reset),
    .lookup_valid   (lookup_valid),
    .lookup_ready   (lookup_ready),
    .PC             (PC),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_out_valid (pred_out_valid),
    .prediction     (prediction),
    .nex_PC         (nex_PC),
    .chosen_idx     (chosen_idx),
    .fix_valid      (fix_valid),
    .fix_result     (fix_result),
    .fix_error      (fix_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic [1:0]  tk;
    logic        fv;
    logic        fr;
    logic        ev;
    logic        ep;
    logic        ei;
    logic [31:0] en;
    logic        er;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic lv, logic [31:0] pc, logic [1:0] tk, logic fv, logic fr,
                              logic ev, logic ep, logic ei, logic [31:0] en, logic er, logic ef);
    vec_t v;
    v.lv = lv; v.pc = pc; v.tk = tk; v.fv = fv; v.fr = fr;
    v.ev = ev; v.ep = ep; v.ei = ei; v.en = en; v.er = er; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] pc, input logic [1:0] tk,
                       input logic fv, input logic fr);
    lookup_valid = lv;
    PC           = pc;
    pred_taken   = tk;
    fix_valid    = fv;
    fix_result   = fr;
  endtask

  initial begin
    pred_target = {T1, T0};
    reset = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);

    // Lookups at 0x40 (idx 0), 0x44 (idx 1), 0x48 (idx 2), 0x50 (idx 4).
    tbl.push_back(mk(1, 32'h40, 2'b10, 0, 0, 1, 0, 0, 32'h44,  1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h40, 2'b10, 0, 0, 1, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h40, 2'b10, 0, 0, 1, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h40, 2'b10, 0, 0, 1, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 0, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h40, 2'b01, 0, 0, 1, 0, 1, 32'h44,  1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h40, 2'b01, 0, 0, 1, 1, 0, 32'h200, 1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h44, 2'b11, 0, 0, 1, 1, 0, 32'h200, 1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 0, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h44, 2'b10, 0, 0, 1, 0, 0, 32'h48,  1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 0, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h48, 2'b10, 0, 0, 1, 0, 0, 32'h4C,  1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h48, 2'b10, 0, 0, 1, 1, 1, 32'h100, 1, 0));
    // Same-cycle lookup and fix on idx 2: lookup must see old (1,3).
    tbl.push_back(mk(1, 32'h48, 2'b10, 1, 0, 1, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(1, 32'h48, 2'b10, 0, 0, 1, 0, 0, 32'h4C,  1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 0, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 0, 0, 0, 0, 32'h0,   1, 0));
    // Fix on an empty queue.
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 1));
    tbl.push_back(mk(0, 32'h0,  2'b00, 0, 0, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h48, 2'b10, 0, 0, 1, 0, 0, 32'h4C,  1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 0, 0, 0, 0, 32'h0,   1, 0));
    // PC+4 wraps modulo 2^32.
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 2'b00, 0, 0, 1, 0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    // Fill the queue, then push+pop while full admits only the pop.
    tbl.push_back(mk(1, 32'h50, 2'b00, 0, 0, 1, 0, 0, 32'h54,  1, 0));
    tbl.push_back(mk(1, 32'h50, 2'b00, 0, 0, 1, 0, 0, 32'h54,  1, 0));
    tbl.push_back(mk(1, 32'h50, 2'b00, 0, 0, 1, 0, 0, 32'h54,  1, 0));
    tbl.push_back(mk(1, 32'h50, 2'b00, 0, 0, 1, 0, 0, 32'h54,  0, 0));
    tbl.push_back(mk(1, 32'h50, 2'b00, 0, 0, 0, 0, 0, 32'h0,   0, 0));
    tbl.push_back(mk(1, 32'h50, 2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    // Counters at 0 must saturate, not wrap.
    tbl.push_back(mk(1, 32'h50, 2'b10, 0, 0, 1, 0, 0, 32'h54,  1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));
    tbl.push_back(mk(1, 32'h50, 2'b10, 0, 0, 1, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(0, 32'h0,  2'b00, 1, 1, 0, 0, 0, 32'h0,   1, 0));

    #12;
    vectors++;
    chk("reset.ready", 32'(lookup_ready), 32'd1);
    chk("reset.valid", 32'(pred_out_valid), 32'd0);
    chk("reset.pred", 32'(prediction), 32'd0);
    chk("reset.nex", nex_PC, 32'd0);
    chk("reset.idx", 32'(chosen_idx), 32'd0);
    chk("reset.ferr", 32'(fix_error), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].lv, tbl[i].pc, tbl[i].tk, tbl[i].fv, tbl[i].fr);
      @(posedge clock);
      #1;
      vectors++;
      chk($sformatf("v%0d.valid", i), 32'(pred_out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d.ready", i), 32'(lookup_ready), 32'(tbl[i].er));
      chk($sformatf("v%0d.ferr", i), 32'(fix_error), 32'(tbl[i].ef));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d.pred", i), 32'(prediction), 32'(tbl[i].ep));
        chk($sformatf("v%0d.idx", i), 32'(chosen_idx), 32'(tbl[i].ei));
        chk($sformatf("v%0d.nex", i), nex_PC, tbl[i].en);
      end
    end

    // Fill the queue at idx 8, then assert reset between clock edges.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h60, 2'b01, 1'b0, 1'b0);
      @(posedge clock);
      #1;
    end
    drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    vectors++;
    chk("full.valid", 32'(pred_out_valid), 32'd1);
    chk("full.ready", 32'(lookup_ready), 32'd0);
    chk("full.nex", nex_PC, 32'h200);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    chk("arst.ready", 32'(lookup_ready), 32'd1);
    chk("arst.valid", 32'(pred_out_valid), 32'd0);
    chk("arst.pred", 32'(prediction), 32'd0);
    chk("arst.nex", nex_PC, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    vectors++;
    chk("arst.fix_error", 32'(fix_error), 32'd1);
    chk("arst.ready2", 32'(lookup_ready), 32'd1);
    // idx 4 held (0,2) before reset; a tie here proves the counters were reinitialised.
    drive(1'b1, 32'h50, 2'b10, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    vectors++;
    chk("arst.look.valid", 32'(pred_out_valid), 32'd1);
    chk("arst.look.idx", 32'(chosen_idx), 32'd0);
    chk("arst.look.nex", nex_PC, 32'h54);
    chk("arst.look.ferr", 32'(fix_error), 32'd0);
    drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    @(posedge clock);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
